gand16_arb: RTL and testbench

Two-port round-robin arbiter and sequencer that shares a single 16-bit combinational AND unit (gand16) between two requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one request at a time, latches its operands, and drives them through the shared gand16 instance. It then returns the registered result with the requester ID over a valid/ready response channel. It sits between the trab1 logic datapaths and any pair of clients that need bitwise AND without duplicating the gate array.

---
 rtl/gand16_arb.sv | 115 +++++++++++
 tb/tb_gand16_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gand16_arb.sv
// Round-robin arbiter that shares one 16-bit AND unit (gand16) between two
// valid/ready requesters and returns the registered result with its owner ID.

module gand16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = a & b;
endmodule

module gand16_arb #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    output logic          req1_ready,
    output logic          rsp_valid,
    output logic [W-1:0]  rsp_y,
    output logic          rsp_id,
    input  logic          rsp_ready,
    output logic          busy,
    output logic [CW-1:0] op_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    logic         prio;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_id;
    logic [W-1:0] and_y;
    logic         gnt0;
    logic         gnt1;

    gand16 u_gand16 (
        .a (op_a),
        .b (op_b),
        .y (and_y)
    );

    // prio=0 favours requester 0 when both are valid; readies are masked in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (req0_valid && (!req1_valid || !prio))
                gnt0 = 1'b1;
            else if (req1_valid)
                gnt1 = 1'b1;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0) begin
                        op_a  <= req0_a;
                        op_b  <= req0_b;
                        op_id <= 1'b0;
                        prio  <= 1'b1;
                        state <= EXEC;
                    end else if (gnt1) begin
                        op_a  <= req1_a;
                        op_b  <= req1_b;
                        op_id <= 1'b1;
                        prio  <= 1'b0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y     <= and_y;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + CW'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gand16_arb.sv
// Directed bench for gand16_arb: expected responses are queued when requests
// are driven and compared when the response handshake completes.

module tb_gand16_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid;
    logic [15:0] rsp_y;
    logic        rsp_id;
    logic        rsp_ready;
    logic        busy;
    logic [7:0]  op_count;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [16:0] sb[$];
    logic [7:0]  exp_count = '0;

    gand16_arb #(.W(16), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_y      (rsp_y),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after inputs settle; pops the scoreboard on a response handshake.
    task automatic tick();
        logic [16:0] e;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e[16]));
                chk("rsp_y", 32'(rsp_y), 32'(e[15:0]));
            end
            exp_count++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        rsp_ready = 1'b1;
        #1;
        chk("op_grant", {req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
        sb.push_back({id, a & b});
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1; tick();
        #1; tick();
    endtask

    initial begin
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(negedge clk);
        #1;
        chk("rst_ready_forced", {req1_ready, req0_ready}, 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single request from requester 0
        rsp_ready = 1'b1; req0_valid = 1'b1; req0_a = 16'hF0F0; req0_b = 16'hFF00;
        #1;
        chk("single_ready0", {req1_ready, req0_ready}, 32'd1);
        sb.push_back({1'b0, 16'hF000});
        tick();
        #1;
        chk("single_exec_ready", {req1_ready, req0_ready}, 32'd0);
        chk("single_exec_valid", 32'(rsp_valid), 32'd0);
        chk("single_exec_busy", 32'(busy), 32'd1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
        #1;
        chk("single_op_count", 32'(op_count), 32'(exp_count));
        chk("single_op_count_1", 32'(op_count), 32'd1);
        chk("single_idle_valid", 32'(rsp_valid), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // Contention: pointer now favours requester 1 after the grant to 0
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h1234;
        req1_valid = 1'b1; req1_a = 16'h00FF; req1_b = 16'hABCD;
        for (int i = 0; i < 6; i++) begin
            logic id;
            id = (i % 2 == 0);
            #1;
            chk("cont_grant", {req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
            sb.push_back(id ? {1'b1, 16'h00CD} : {1'b0, 16'h1234});
            tick();
            #1;
            chk("cont_exec_ready", {req1_ready, req0_ready}, 32'd0);
            tick();
            #1;
            chk("cont_rsp_valid", 32'(rsp_valid), 32'd1);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("cont_op_count", 32'(op_count), 32'd7);

        // Backpressure on a requester-1 response
        rsp_ready = 1'b0; req1_valid = 1'b1; req1_a = 16'hAAAA; req1_b = 16'h5555;
        #1;
        chk("bp_grant", {req1_ready, req0_ready}, 32'd2);
        sb.push_back({1'b1, 16'h0000});
        tick();
        req1_valid = 1'b0;
        #1; tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_y", 32'(rsp_y), 32'h0000);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_ready", {req1_ready, req0_ready}, 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        #1; tick();
        #1;
        chk("bp_done_busy", 32'(busy), 32'd0);
        chk("bp_op_count", 32'(op_count), 32'd8);

        // Reset while in RESP: response discarded
        rsp_ready = 1'b0; req0_valid = 1'b1; req0_a = 16'h0F0F; req0_b = 16'h00FF;
        #1; tick();
        req0_valid = 1'b0;
        #1; tick();
        #1;
        chk("rstm_in_resp", 32'(rsp_valid), 32'd1);
        rst = 1'b1; req1_valid = 1'b1; req1_a = 16'h1357; req1_b = 16'hFF0F;
        #1;
        chk("rstm_ready_forced", {req1_ready, req0_ready}, 32'd0);
        tick();
        exp_count = '0;
        rst = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("rstm_valid", 32'(rsp_valid), 32'd0);
        chk("rstm_op_count", 32'(op_count), 32'd0);
        chk("rstm_busy", 32'(busy), 32'd0);
        chk("rstm_grant1", {req1_ready, req0_ready}, 32'd2);
        sb.push_back({1'b1, 16'h1307});
        tick();
        req1_valid = 1'b0;
        #1; tick();
        #1; tick();
        #1;
        chk("rstm_op_count_after", 32'(op_count), 32'd1);

        // Reset in EXEC after a grant to 0: pointer must return to favour 0
        rsp_ready = 1'b0; req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        #1; tick();
        req0_valid = 1'b0; rst = 1'b1;
        #1; tick();
        exp_count = '0;
        rst = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h3333; req0_b = 16'h0FF0;
        req1_valid = 1'b1; req1_a = 16'h4444; req1_b = 16'hFFFF;
        #1;
        chk("ptr_reset_grant0", {req1_ready, req0_ready}, 32'd1);
        sb.push_back({1'b0, 16'h0330});
        tick();
        #1; tick();
        #1; tick();
        #1;
        chk("ptr_reset_grant1", {req1_ready, req0_ready}, 32'd2);
        sb.push_back({1'b1, 16'h4444});
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1; tick();
        #1; tick();

        // Operand isolation: inputs change after the accept edge
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        #1;
        chk("iso_grant", {req1_ready, req0_ready}, 32'd1);
        sb.push_back({1'b0, 16'hFFFF});
        tick();
        req0_valid = 1'b0; req0_a = 16'h0000;
        #1; tick();
        #1;
        chk("iso_y", 32'(rsp_y), 32'hFFFF);
        tick();

        // Counter wrap: fresh reset, then 255 ops, then one more
        rst = 1'b1;
        #1; tick();
        rst = 1'b0; exp_count = '0;
        for (int i = 0; i < 255; i++)
            do_op(1'(i % 2), 16'($urandom), 16'($urandom));
        #1;
        chk("wrap_255", 32'(op_count), 32'd255);
        chk("wrap_model_255", 32'(op_count), 32'(exp_count));
        do_op(1'b1, 16'hC3C3, 16'h0FF0);
        #1;
        chk("wrap_0", 32'(op_count), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
